// File: rtl/sprite_row_renderer.sv
// Per-scanline sprite row renderer: fetches one ROM row, then streams scaled 1-bpp pixels at sprx.
// Optional horizontal mirroring is enabled by defining SPRITE_ROW_RENDERER_FLIP_EN.
module sprite_row_renderer #(
   parameter int unsigned SPR_W   = 8,
   parameter int unsigned SPR_H   = 8,
   parameter int unsigned SCALE_X = 1,
   parameter int unsigned SCALE_Y = 1,
   parameter int unsigned CORDW   = 16,
   parameter int unsigned ADDRW   = $clog2(SPR_H)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    line,
   input  logic signed [CORDW-1:0] sx,
   input  logic signed [CORDW-1:0] sy,
   input  logic signed [CORDW-1:0] sprx,
   input  logic signed [CORDW-1:0] spry,
   input  logic                    flip,
   output logic [ADDRW-1:0]        rom_addr,
   input  logic [SPR_W-1:0]        rom_data,
   output logic                    pix,
   output logic                    drawing,
   output logic                    done
);

   localparam int unsigned DRAW_N = SPR_W * SCALE_X;
   localparam int unsigned ROWS_N = SPR_H * SCALE_Y;
   localparam int unsigned CNTW   = $clog2(DRAW_N);
   localparam int unsigned YSH    = $clog2(SCALE_Y);

   typedef enum logic [2:0] {IDLE, REG_POS, LOAD, WAIT_POS, DRAW, DONE} state_t;

   state_t                  state_q, state_d;
   logic signed [CORDW-1:0] sprx_q, sprx_d;
   logic [SPR_W-1:0]        shift_q, shift_d;
   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic [ADDRW-1:0]        rom_addr_q, rom_addr_d;
   logic                    pix_q, pix_d;
   logic                    drawing_q, drawing_d;
   logic                    done_q, done_d;
   logic [CORDW:0]          dy;
   logic                    dy_in_range;
   logic [ADDRW-1:0]        dy_row;
   logic [SPR_W-1:0]        load_row;

   // Row offset at one extra bit so sprites straddling the sign boundary compare correctly
   assign dy          = {sy[CORDW-1], sy} - {spry[CORDW-1], spry};
   assign dy_in_range = !dy[CORDW] && (dy[CORDW-1:0] < CORDW'(ROWS_N));
   assign dy_row      = ADDRW'(dy[CORDW-1:0] >> YSH);

`ifdef SPRITE_ROW_RENDERER_FLIP_EN
   logic flip_q, flip_d;
   logic [SPR_W-1:0] row_rev;

   always_comb begin
      row_rev = '0;
      for (int i = 0; i < int'(SPR_W); i++) row_rev[i] = rom_data[int'(SPR_W)-1-i];
   end

   assign load_row = flip_q ? row_rev : rom_data;
`else
   logic unused_flip;

   assign unused_flip = flip;
   assign load_row    = rom_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sprx_q     <= '0;
         shift_q    <= '0;
         cnt_q      <= '0;
         rom_addr_q <= '0;
         pix_q      <= 1'b0;
         drawing_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef SPRITE_ROW_RENDERER_FLIP_EN
         flip_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sprx_q     <= sprx_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         rom_addr_q <= rom_addr_d;
         pix_q      <= pix_d;
         drawing_q  <= drawing_d;
         done_q     <= done_d;
`ifdef SPRITE_ROW_RENDERER_FLIP_EN
         flip_q     <= flip_d;
`endif
      end
   end

   // Next state plus next values of the registered outputs (they describe the following cycle)
   always_comb begin
      state_d    = state_q;
      sprx_d     = sprx_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      rom_addr_d = rom_addr_q;
      pix_d      = 1'b0;
      drawing_d  = 1'b0;
      done_d     = 1'b0;
`ifdef SPRITE_ROW_RENDERER_FLIP_EN
      flip_d     = flip_q;
`endif
      if (line) begin
         state_d = REG_POS;
      end else begin
         case (state_q)
            IDLE: ;
            REG_POS: begin
               sprx_d = sprx;
`ifdef SPRITE_ROW_RENDERER_FLIP_EN
               flip_d = flip;
`endif
               if (dy_in_range) begin
                  state_d    = LOAD;
                  rom_addr_d = dy_row;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
            LOAD: begin
               shift_d = load_row;
               state_d = WAIT_POS;
            end
            WAIT_POS: begin
               if (sx == sprx_q) begin
                  state_d   = DRAW;
                  cnt_d     = '0;
                  drawing_d = 1'b1;
                  pix_d     = shift_q[SPR_W-1];
               end
            end
            DRAW: begin
               if (cnt_q == CNTW'(DRAW_N - 1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
                  // Advance to the next source pixel once it has been shown SCALE_X times
                  if ((cnt_q & CNTW'(SCALE_X - 1)) == CNTW'(SCALE_X - 1)) shift_d = shift_q << 1;
                  drawing_d = 1'b1;
                  pix_d     = shift_d[SPR_W-1];
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign rom_addr = rom_addr_q;
   assign pix      = pix_q;
   assign drawing  = drawing_q;
   assign done     = done_q;

endmodule
